// File: rtl/conv_window_gen.sv
// conv_window_gen: line-buffered 5x5 sliding-window generator with valid/ready.
// Define CONV_WINDOW_STRIDE2_EN to emit only windows on even coordinates.
module conv_window_gen #(
  parameter int BITWIDTH = 16,
  parameter int IMG_W    = 28,
  parameter int IMG_H    = 28
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic signed [BITWIDTH-1:0]           in_pixel,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic signed [4:0][4:0][BITWIDTH-1:0] map_block,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 out_last
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] C_MIN  = CW'(4);
  localparam logic [RW-1:0] R_MIN  = RW'(4);

  typedef logic [BITWIDTH-1:0] pix_t;
  typedef logic [4:0][4:0][BITWIDTH-1:0] win_t;

  pix_t          lb_q [4][IMG_W];
  win_t          win_q, win_d;
  win_t          map_q;
  logic [CW-1:0] c_q, c_d;
  logic [RW-1:0] r_q, r_d;
  logic          ov_q, ol_q;
  logic          in_fire, out_fire;
  logic          at_win, is_last, emit;

  assign in_ready  = !ov_q || out_ready;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = ov_q && out_ready;
  assign map_block = map_q;
  assign out_valid = ov_q;
  assign out_last  = ol_q;

`ifdef CONV_WINDOW_STRIDE2_EN
  localparam logic [CW-1:0] C_FIN = CW'(((IMG_W - 1) / 2) * 2);
  localparam logic [RW-1:0] R_FIN = RW'(((IMG_H - 1) / 2) * 2);
  assign at_win  = (r_q >= R_MIN) && (c_q >= C_MIN)
                && !r_q[0] && !c_q[0];
  assign is_last = (r_q == R_FIN) && (c_q == C_FIN);
`else
  assign at_win  = (r_q >= R_MIN) && (c_q >= C_MIN);
  assign is_last = (r_q == R_LAST) && (c_q == C_LAST);
`endif

  assign emit = in_fire && at_win;

  always_comb begin
    c_d = c_q + 1'b1;
    r_d = r_q;
    if (c_q == C_LAST) begin
      c_d = '0;
      r_d = (r_q == R_LAST) ? '0 : r_q + 1'b1;
    end
  end

  // Row i of the incoming column is image row r-4+i.
  always_comb begin
    win_d = win_q;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 4; j++) begin
        win_d[i][j] = win_q[i][j+1];
      end
    end
    for (int i = 0; i < 4; i++) begin
      win_d[i][4] = lb_q[i][c_q];
    end
    win_d[4][4] = in_pixel;
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      for (int k = 0; k < 3; k++) begin
        lb_q[k][c_q] <= lb_q[k+1][c_q];
      end
      lb_q[3][c_q] <= in_pixel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q   <= '0;
      r_q   <= '0;
      win_q <= '0;
      map_q <= '0;
      ov_q  <= 1'b0;
      ol_q  <= 1'b0;
    end else begin
      if (in_fire) begin
        c_q   <= c_d;
        r_q   <= r_d;
        win_q <= win_d;
      end
      if (emit) begin
        map_q <= win_d;
        ov_q  <= 1'b1;
        ol_q  <= is_last;
      end else if (out_fire) begin
        ov_q  <= 1'b0;
        ol_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: table-driven runs of an 8x6 and a 28x28 instance
// against a frame-array window model, plus an async-reset sequence.
`timescale 1ns/1ps
module tb_conv_window_gen;
  localparam int BW = 16;
`ifdef CONV_WINDOW_STRIDE2_EN
  localparam int STRIDE = 2;
  localparam int L44    = 'h46;
`else
  localparam int STRIDE = 1;
  localparam int L44    = 'h57;
`endif
  localparam int NS = ((6 - 5) / STRIDE + 1) * ((8 - 5) / STRIDE + 1);
  localparam int NB = ((28 - 5) / STRIDE + 1) * ((28 - 5) / STRIDE + 1);
  localparam int MAXCYC = 30000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic sel;
  logic signed [BW-1:0] t_pixel;
  logic t_valid, t_oready;
  logic s_ir, s_ov, s_ol, b_ir, b_ov, b_ol;
  logic signed [4:0][4:0][BW-1:0] s_map, b_map;
  logic m_ir, m_ov, m_ol;
  logic [4:0][4:0][BW-1:0] m_map;

  assign m_ir  = sel ? b_ir : s_ir;
  assign m_ov  = sel ? b_ov : s_ov;
  assign m_ol  = sel ? b_ol : s_ol;
  assign m_map = sel ? b_map : s_map;

  conv_window_gen #(.BITWIDTH(BW), .IMG_W(8), .IMG_H(6)) u_s (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_pixel  (t_pixel),
    .in_valid  (t_valid && !sel),
    .in_ready  (s_ir),
    .map_block (s_map),
    .out_valid (s_ov),
    .out_ready (t_oready && !sel),
    .out_last  (s_ol)
  );

  conv_window_gen #(.BITWIDTH(BW), .IMG_W(28), .IMG_H(28)) u_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_pixel  (t_pixel),
    .in_valid  (t_valid && sel),
    .in_ready  (b_ir),
    .map_block (b_map),
    .out_valid (b_ov),
    .out_ready (t_oready && sel),
    .out_last  (b_ol)
  );

  typedef struct packed {
    logic [4:0][4:0][BW-1:0] w;
    logic                    last;
  } win_t;

  typedef struct {
    bit sel;
    int w;
    int h;
    int frames;
    int mode;
    bit rnd;
    int n_exp;
    bit chk44;
    int first44;
    int last44;
  } vec_t;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [399:0] got,
                     input logic [399:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // mode 0: always valid/ready, 1: random 50%, 2: stall 10 after 1st window
  task automatic run(input vec_t v);
    logic [BW-1:0] fr [3][28][28];
    logic [BW-1:0] px [$];
    win_t exp_q [$];
    win_t e, e_first;
    int idx, got, nl, cyc, stall;
    bit seen, stalled;
    logic [BW-1:0] g_first, g_last;
    for (int f = 0; f < v.frames; f++)
      for (int r = 0; r < v.h; r++)
        for (int c = 0; c < v.w; c++) begin
          fr[f][r][c] = v.rnd ? BW'($urandom) : BW'(f*256 + r*16 + c);
          px.push_back(fr[f][r][c]);
        end
    for (int f = 0; f < v.frames; f++) begin
      for (int tr = 0; tr + 4 < v.h; tr += STRIDE)
        for (int tc = 0; tc + 4 < v.w; tc += STRIDE) begin
          for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
              e.w[i][j] = fr[f][tr+i][tc+j];
          e.last = 1'b0;
          exp_q.push_back(e);
        end
      e = exp_q.pop_back();
      e.last = 1'b1;
      exp_q.push_back(e);
    end
    e_first = exp_q[0];
    sel = v.sel;
    idx = 0; got = 0; nl = 0; cyc = 0; stall = 0;
    seen = 1'b0; stalled = 1'b0;
    g_first = '0; g_last = '0;
    while ((idx < px.size() || exp_q.size() > 0 || m_ov) && cyc < MAXCYC) begin
      @(posedge clk); #1;
      cyc++;
      if (v.mode == 2 && m_ov && !stalled) begin
        stall = 10;
        stalled = 1'b1;
      end
      t_valid  = (idx < px.size()) && (v.mode != 1 || $urandom_range(1, 0) == 1);
      t_pixel  = (idx < px.size()) ? px[idx] : '0;
      t_oready = (v.mode == 1) ? ($urandom_range(1, 0) == 1) : (stall == 0);
      @(negedge clk);
      chk("in_ready", m_ir, !m_ov || t_oready);
      if (m_ov && !seen) begin
        seen = 1'b1;
        chk("latency", (idx > 0) ? px[idx-1] : '1, e_first.w[4][4]);
      end
      if (stall > 0) begin
        chk("hold_valid", m_ov, 1'b1);
        chk("hold_ready", m_ir, 1'b0);
        chk("hold_map", m_map, e_first.w);
        stall--;
      end
      if (m_ov && t_oready) begin
        if (exp_q.size() == 0) begin
          chk("extra_window", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("window", m_map, e.w);
          chk("last", m_ol, e.last);
        end
        if (got == 0) g_first = m_map[4][4];
        g_last = m_map[4][4];
        got++;
        if (m_ol) nl++;
      end
      if (t_valid && m_ir) idx++;
    end
    t_valid = 1'b0;
    t_oready = 1'b0;
    chk("timeout", cyc >= MAXCYC, 1'b0);
    chk("count", got, v.n_exp);
    chk("last_pulses", nl, v.frames);
    if (v.chk44) begin
      chk("first44", g_first, v.first44);
      chk("last44", g_last, v.last44);
    end
  endtask

  vec_t tbl [5];
  int k, cyc;

  initial begin
    tbl[0] = '{1'b0,  8, 6, 1, 0, 1'b0, NS,   1'b1, 'h44, L44};
    tbl[1] = '{1'b0,  8, 6, 1, 2, 1'b0, NS,   1'b1, 'h44, L44};
    tbl[2] = '{1'b0,  8, 6, 2, 0, 1'b0, 2*NS, 1'b1, 'h44, 'h100 + L44};
    tbl[3] = '{1'b0,  8, 6, 2, 1, 1'b1, 2*NS, 1'b0, 0, 0};
    tbl[4] = '{1'b1, 28, 28, 3, 1, 1'b1, 3*NB, 1'b0, 0, 0};

    sel = 1'b0;
    t_valid = 1'b0;
    t_oready = 1'b0;
    t_pixel = '0;
    rst_n = 1'b0;
    #1;
    chk("rst_s_ov", s_ov, 1'b0);
    chk("rst_s_ol", s_ol, 1'b0);
    chk("rst_s_map", s_map, '0);
    chk("rst_b_ov", b_ov, 1'b0);
    chk("rst_b_map", b_map, '0);
    chk("rst_s_ir", s_ir, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 5; t++) run(tbl[t]);

    // Reset while a window is held: it must vanish without a clock edge.
    sel = 1'b0;
    k = 0;
    cyc = 0;
    while (k < 37 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      t_valid  = 1'b1;
      t_pixel  = BW'((k / 8) * 16 + (k % 8));
      t_oready = 1'b0;
      @(negedge clk);
      if (s_ir) k++;
    end
    @(posedge clk); #1;
    t_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_count", k, 37);
    chk("pre_rst_ov", s_ov, 1'b1);
    chk("pre_rst_ir", s_ir, 1'b0);
    chk("pre_rst_44", s_map[4][4], 'h44);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_ov", s_ov, 1'b0);
    chk("async_ol", s_ol, 1'b0);
    chk("async_map", s_map, '0);
    chk("async_ir", s_ir, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    run(tbl[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
